fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of the Decoder. Holds the program counter and issues word reads to instruction memory over a valid/ready request channel with variable-latency responses. Buffers returned words in a small queue and presents them, with their PC, to the Decoder's `instruction` input under a stall signal. Accepts redirects (branch/jump/exception) that flush all fetched and in-flight work.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encodings, instruction
// word size in bytes and the default reset PC.
package fetch_pkg;

  localparam int unsigned INSTRUCTION_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  // Fetch FSM encodings
  localparam int unsigned    STATE_W  = 2;
  localparam logic [1:0]     ST_IDLE  = 2'd0;  // no request outstanding
  localparam logic [1:0]     ST_WAIT  = 2'd1;  // one request outstanding, response kept
  localparam logic [1:0]     ST_DRAIN = 2'd2;  // one request outstanding, response discarded

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instruction} pairs between instruction memory
// and the Decoder. Head outputs read as zero while the queue is empty.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   push, push_pc,   write one entry (ignored when full with no pop)
//   push_data
//   pop              remove the head entry (ignored when empty)
//   flush            drop all entries; overrides push and pop
//   count            current occupancy, 0..DEPTH
//   head_pc,         oldest entry, zero when empty
//   head_data
module fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [PC_W-1:0]          push_pc,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [PC_W-1:0]          head_pc,
  output logic [DATA_W-1:0]        head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              not_empty;
  logic              do_pop;
  logic              do_push;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // A full queue can still accept a push when the head leaves the same cycle
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage, no reset needed since reads are masked while empty
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      pc_mem[wr_ptr]   <= push_pc;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_pc   = not_empty ? pc_mem[rd_ptr]   : '0;
  assign head_data = not_empty ? data_mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory, queues returned words and hands them to the Decoder.
// Redirects flush the queue and discard any in-flight response.
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr       read request channel (valid is combinational
//                                   from imem_resp_valid and redirect_valid)
//   imem_resp_valid/data            in-order read responses, one per request
//   redirect_valid/redirect_pc      one-cycle redirect to a new fetch address
//   stall                           Decoder cannot take an instruction
//   instruction/_pc/_valid          queue head presented to the Decoder
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned             ADDRESS_SIZE     = 32,
  parameter int unsigned             INSTRUCTION_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC         = ADDRESS_SIZE'(DEFAULT_RESET_PC),
  parameter int unsigned             QUEUE_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [ADDRESS_SIZE-1:0]     imem_req_addr,
  input  logic                        imem_resp_valid,
  input  logic [INSTRUCTION_SIZE-1:0] imem_resp_data,
  input  logic                        redirect_valid,
  input  logic [ADDRESS_SIZE-1:0]     redirect_pc,
  input  logic                        stall,
  output logic [0:INSTRUCTION_SIZE-1] instruction,
  output logic [ADDRESS_SIZE-1:0]     instruction_pc,
  output logic                        instruction_valid
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [STATE_W-1:0]          state;
  logic [STATE_W-1:0]          state_nxt;
  logic [ADDRESS_SIZE-1:0]     fetch_pc;
  logic [ADDRESS_SIZE-1:0]     req_pc;
  logic [CNT_W-1:0]            count;
  logic [OCC_W-1:0]            occupancy;
  logic                        issue_slot;
  logic                        handshake;
  logic                        push;
  logic                        pop;
  logic [INSTRUCTION_SIZE-1:0] head_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request issue, response acceptance and next-state selection
  always_comb begin
    state_nxt = state;
    // Reserve a queue slot for the outstanding word; a same-cycle pop is not credited
    occupancy  = OCC_W'(count) + OCC_W'(state == ST_WAIT);
    issue_slot = (state == ST_IDLE) || ((state == ST_WAIT) && imem_resp_valid);
    imem_req_valid = issue_slot && (occupancy < OCC_W'(QUEUE_DEPTH))
                     && !redirect_valid && !reset;
    handshake = imem_req_valid && imem_req_ready;
    push      = (state == ST_WAIT) && imem_resp_valid && !redirect_valid;

    if (redirect_valid) begin
      unique case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_WAIT:  state_nxt = imem_resp_valid ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: state_nxt = imem_resp_valid ? ST_IDLE : ST_DRAIN;
        default:  state_nxt = ST_IDLE;
      endcase
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (handshake) state_nxt = ST_WAIT;
        end
        ST_WAIT, ST_DRAIN: begin
          if (imem_resp_valid) state_nxt = handshake ? ST_WAIT : ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fetch PC and the PC of the outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~ADDRESS_SIZE'(INSTRUCTION_BYTES - 1);
    end else if (handshake) begin
      fetch_pc <= fetch_pc + ADDRESS_SIZE'(INSTRUCTION_BYTES);
      req_pc   <= fetch_pc;
    end
  end

  assign imem_req_addr     = fetch_pc;
  assign instruction_valid = (count != '0);
  assign pop               = instruction_valid && !stall;

  fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .PC_W   (ADDRESS_SIZE),
    .DATA_W (INSTRUCTION_SIZE)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_pc   (req_pc),
    .push_data (imem_resp_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_pc   (instruction_pc),
    .head_data (head_data)
  );

  assign instruction = head_data;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a variable-latency memory responder, an
// in-order stream checker on the Decoder side and hand-computed cycle checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [0:31] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;

  int checks = 0;
  int errors = 0;

  // Memory responder state
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          lat      = 1;

  // Expected streams
  logic [31:0] exp_req   = '0;
  logic [31:0] exp_pc    = '0;
  int          consumed  = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = '0;

  fetch_stage #(
    .ADDRESS_SIZE     (32),
    .INSTRUCTION_SIZE (32),
    .RESET_PC         (32'h0000_0000),
    .QUEUE_DEPTH      (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .stall             (stall),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present this cycle's memory response (word data is ~address)
  task automatic drive();
    imem_resp_valid = mem_pend && (mem_cnt == 1);
    imem_resp_data  = imem_resp_valid ? ~mem_addr : 32'hDEAD_BEEF;
    #1;
  endtask

  // Per-cycle stream/protocol checks, then clock edge and responder update
  task automatic adv();
    logic        hs;
    logic [31:0] hs_addr;
    if (!reset && !redirect_valid && instruction_valid && !stall) begin
      chk("stream_pc", instruction_pc, exp_pc);
      chk("stream_data", instruction, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (!instruction_valid) begin
      chk("empty_pc_zero", instruction_pc, 32'h0);
      chk("empty_instr_zero", instruction, 32'h0);
    end
    if (hold_pend && !reset && !redirect_valid) begin
      chk("hold_valid", 32'(imem_req_valid), 32'd1);
      chk("hold_addr", imem_req_addr, hold_addr);
    end
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    if (hs) begin
      chk("req_addr", hs_addr, exp_req);
      chk("one_outstanding", 32'(mem_pend && !imem_resp_valid), 32'd0);
      exp_req = exp_req + 32'd4;
    end
    hold_pend = imem_req_valid && !imem_req_ready;
    hold_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (imem_resp_valid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (hs) begin
      mem_pend = 1'b1;
      mem_cnt  = lat;
      mem_addr = hs_addr;
    end
  endtask

  task automatic cyc();
    drive();
    adv();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instruction_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_instr_pc", instruction_pc, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(posedge clk);
    #1;
    cyc();
    drive(); chk_reset_outputs(); adv();

    // Streaming with 1-cycle memory
    reset = 1'b0;
    drive(); chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0); adv();
    drive(); chk("c1_req_addr", imem_req_addr, 32'h4);
    chk("c1_not_valid", 32'(instruction_valid), 32'd0); adv();
    drive(); chk("first_valid", 32'(instruction_valid), 32'd1);
    chk("first_pc", instruction_pc, 32'h0); adv();
    repeat (7) cyc();
    chk("throughput", 32'(consumed), 32'd8);

    // Stall fills the queue and suppresses requests
    stall = 1'b1;
    repeat (3) cyc();
    drive(); chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_head_pc", instruction_pc, 32'h20); adv();
    repeat (2) cyc();
    stall = 1'b0;
    drive(); chk("pop_not_credited", 32'(imem_req_valid), 32'd0); adv();
    drive(); chk("refill_req", 32'(imem_req_valid), 32'd1);
    chk("refill_addr", imem_req_addr, 32'h30); adv();
    repeat (4) cyc();
    chk("resume_count", 32'(consumed), 32'd14);

    // Memory not ready for 3 cycles: address must hold
    imem_req_ready = 1'b0;
    repeat (3) begin
      drive(); chk("nrdy_req_valid", 32'(imem_req_valid), 32'd1);
      chk("nrdy_req_addr", imem_req_addr, 32'h44); adv();
    end
    imem_req_ready = 1'b1;
    lat = 3;
    drive(); chk("bubble_after_nrdy", 32'(instruction_valid), 32'd0); adv();

    // Redirect while waiting on a 3-cycle memory
    drive(); chk("wait_no_req", 32'(imem_req_valid), 32'd0); adv();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    drive(); chk("redir_no_req", 32'(imem_req_valid), 32'd0); adv();
    redirect_valid = 1'b0;
    exp_pc = 32'h100; exp_req = 32'h100;
    drive(); chk("drain_no_req", 32'(imem_req_valid), 32'd0);
    chk("redir_flush", 32'(instruction_valid), 32'd0); adv();
    drive(); chk("redir_req_addr", imem_req_addr, 32'h100);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1); adv();
    repeat (3) cyc();
    drive(); chk("redir_first_valid", 32'(instruction_valid), 32'd1);
    chk("redir_first_pc", instruction_pc, 32'h100); adv();

    // Redirect coincident with a response into a nearly full queue
    lat = 1; stall = 1'b1;
    repeat (10) cyc();
    stall = 1'b0;
    drive(); chk("f_full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("f_head_pc", instruction_pc, 32'h104); adv();
    stall = 1'b1; lat = 3;
    drive(); chk("f_req_addr", imem_req_addr, 32'h114);
    chk("f_req_valid", 32'(imem_req_valid), 32'd1); adv();
    repeat (2) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    drive(); chk("f_redir_no_req", 32'(imem_req_valid), 32'd0); adv();
    redirect_valid = 1'b0; stall = 1'b0; lat = 1;
    exp_pc = 32'h200; exp_req = 32'h200;
    drive(); chk("f_flushed", 32'(instruction_valid), 32'd0);
    chk("f_new_req_valid", 32'(imem_req_valid), 32'd1);
    chk("f_new_req_addr", imem_req_addr, 32'h200); adv();
    cyc();
    drive(); chk("f_first_pc", instruction_pc, 32'h200);
    chk("f_first_valid", 32'(instruction_valid), 32'd1); adv();
    repeat (4) cyc();

    // Reset while a 3-cycle request is outstanding
    lat = 3;
    cyc();
    reset = 1'b1; imem_req_ready = 1'b0;
    exp_pc = 32'h0; exp_req = 32'h0;
    cyc();
    drive(); chk_reset_outputs(); adv();
    reset = 1'b0;
    drive(); chk("late_resp_seen", 32'(imem_resp_valid), 32'd1);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0); adv();
    imem_req_ready = 1'b1; lat = 1;
    drive(); chk("late_resp_ignored", 32'(instruction_valid), 32'd0); adv();
    cyc();
    drive(); chk("post_rst_valid", 32'(instruction_valid), 32'd1);
    chk("post_rst_pc", instruction_pc, 32'h0); adv();
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
